// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the datapath and the pipeline sequencer.
//  master : datapath side, drives hazard inputs, consumes stage controls/stats
//  slave  : hazard_ctrl side
//  Inputs : ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rs, id_rt,
//           id_uses_rt, br_taken, halt_mem
//  Outputs: pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, idex_flush_br,
//           exmem_en, exmem_flush, memwb_en, halted, lduse_cnt, freeze_cnt, brflush_cnt
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             ihit, dhit, mem_dreq;
  logic             ex_memread;
  logic [4:0]       ex_wsel, id_rs, id_rt;
  logic             id_uses_rt, br_taken, halt_mem;
  logic             pc_en, ifid_en, ifid_flush;
  logic             idex_stall, idex_flush, idex_flush_br;
  logic             exmem_en, exmem_flush, memwb_en;
  logic             halted;
  logic [CNT_W-1:0] lduse_cnt, freeze_cnt, brflush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rs, id_rt,
           id_uses_rt, br_taken, halt_mem,
    input  pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, idex_flush_br,
           exmem_en, exmem_flush, memwb_en, halted, lduse_cnt, freeze_cnt, brflush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rs, id_rt,
           id_uses_rt, br_taken, halt_mem,
    output pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, idex_flush_br,
           exmem_en, exmem_flush, memwb_en, halted, lduse_cnt, freeze_cnt, brflush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage MIPS core.
//  Each cycle decides whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold
//  or take a bubble (load-use, EX-resolved branch, D-miss freeze, HALT drain),
//  and keeps saturating hazard statistics.
//  Ports: CLK, nRST (async, active-low), hz (hazard_ctrl_if.slave).
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int HALT_DRAIN = 2
) (
  input  logic     CLK,
  input  logic     nRST,
  hazard_ctrl_if.slave hz
);
  localparam int DW = (HALT_DRAIN < 2) ? 1 : $clog2(HALT_DRAIN + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic             halted_q;
  logic [CNT_W-1:0] lduse_q, freeze_q, brflush_q;

  logic freeze, adv, lduse;
  logic pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, idex_flush_br;
  logic exmem_en, exmem_flush, memwb_en;

  assign freeze = hz.mem_dreq & ~hz.dhit;
  assign adv    = hz.ihit & ~freeze;
  assign lduse  = hz.ex_memread & (hz.ex_wsel != 5'd0) &
                  ((hz.ex_wsel == hz.id_rs) | (hz.id_uses_rt & (hz.ex_wsel == hz.id_rt)));

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_stall    = 1'b0;
    idex_flush    = 1'b0;
    idex_flush_br = 1'b0;
    exmem_en      = 1'b0;
    exmem_flush   = 1'b0;
    memwb_en      = 1'b0;
    if (nRST) begin
      case (state)
        RUN: begin
          // A taken branch squashes the younger load-use instr, so it still lets PC load.
          pc_en         = adv & (~lduse | hz.br_taken);
          ifid_en       = adv & ~lduse;
          ifid_flush    = adv & hz.br_taken;
          idex_stall    = freeze;
          idex_flush    = lduse & ~hz.br_taken & ~freeze;
          idex_flush_br = adv & hz.br_taken;
          exmem_en      = adv | hz.dhit;
          memwb_en      = adv | hz.dhit;
          // MEM instr retires while fetch waits: bubble behind it so ID/EX is not issued twice.
          exmem_flush   = hz.dhit & ~hz.ihit;
        end
        DRAIN: begin
          idex_stall  = 1'b1;
          exmem_en    = adv | hz.dhit;
          memwb_en    = adv | hz.dhit;
          exmem_flush = adv | hz.dhit;
        end
        default: idex_stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= DW'(HALT_DRAIN);
      halted_q  <= 1'b0;
      lduse_q   <= '0;
      freeze_q  <= '0;
      brflush_q <= '0;
    end else begin
      case (state)
        RUN: if (hz.halt_mem & adv) begin
          state     <= DRAIN;
          drain_cnt <= DW'(HALT_DRAIN);
        end
        DRAIN: if (adv) begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        default: halted_q <= 1'b1;
      endcase
      if (state != HALTED) begin
        if (idex_flush & hz.ihit & (lduse_q != '1)) lduse_q   <= lduse_q + CNT_W'(1);
        if (freeze & (freeze_q != '1))              freeze_q  <= freeze_q + CNT_W'(1);
        if (idex_flush_br & (brflush_q != '1))      brflush_q <= brflush_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_en         = pc_en;
  assign hz.ifid_en       = ifid_en;
  assign hz.ifid_flush    = ifid_flush;
  assign hz.idex_stall    = idex_stall;
  assign hz.idex_flush    = idex_flush;
  assign hz.idex_flush_br = idex_flush_br;
  assign hz.exmem_en      = exmem_en;
  assign hz.exmem_flush   = exmem_flush;
  assign hz.memwb_en      = memwb_en;
  assign hz.halted        = halted_q;
  assign hz.lduse_cnt     = lduse_q;
  assign hz.freeze_cnt    = freeze_q;
  assign hz.brflush_cnt   = brflush_q;
endmodule
